// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the ML-KEM accumulator sequencer.
package acc_seq_pkg;

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned K_W    = 3;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned WDT_W  = 16;

    localparam logic [K_W-1:0] RANK_MIN = 3'd2;
    localparam logic [K_W-1:0] RANK_MAX = 3'd4;

    localparam logic [MODE_W-1:0] ACC_MODE_OFF    = 2'b00;
    localparam logic [MODE_W-1:0] ACC_MODE_FIRST  = 2'b10;
    localparam logic [MODE_W-1:0] ACC_MODE_NORMAL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PROD      = 3'd1,
        S_WAIT_PROD = 3'd2,
        S_ACC_GO    = 3'd3,
        S_WAIT_ACC  = 3'd4,
        S_ACC_REL   = 3'd5,
        S_ROW_RDY   = 3'd6,
        S_DONE      = 3'd7
    } state_e;

    // Registered control bundle presented to the product unit, accumulator and consumer.
    typedef struct packed {
        logic              busy;
        logic              done;
        logic              prod_start;
        logic              acc_end_op_ntt;
        logic              acc_load;
        logic              acc_read;
        logic              row_valid;
        logic [MODE_W-1:0] acc_mode;
    } ctl_t;

    function automatic logic rank_legal(input logic [K_W-1:0] k, input int unsigned k_max);
        return (k >= RANK_MIN) && (k <= RANK_MAX) && (32'(k) <= k_max);
    endfunction

    // Accumulator mode is decided only by the state and the current column.
    function automatic logic [MODE_W-1:0] mode_of(input state_e s, input logic [IDX_W-1:0] c);
        logic [MODE_W-1:0] m;
        m = ACC_MODE_OFF;
        if (s != S_IDLE && s != S_DONE) begin
            m = (c == '0) ? ACC_MODE_FIRST : ACC_MODE_NORMAL;
        end
        return m;
    endfunction

endpackage

// File: rtl/acc_seq_wdt.sv
// Wait-state watchdog for acc_seq; counts consecutive cycles spent in a wait state.
module acc_seq_wdt
    import acc_seq_pkg::*;
#(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic fire_c
);

    localparam logic [WDT_W-1:0] LIMIT_M1 = WDT_W'(LIMIT - 1);

    logic [WDT_W-1:0] cnt_q;

    // Fires on the LIMIT-th consecutive wait cycle.
    assign fire_c = en && (cnt_q == LIMIT_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + WDT_W'(1);
        end
    end

endmodule

// File: rtl/acc_seq.sv
// Row-by-row k x k matrix-vector schedule for the NTT-domain accumulator.
// Optional wait-state watchdog enabled by defining ACC_SEQ_TIMEOUT_EN.
module acc_seq
    import acc_seq_pkg::*;
#(
    parameter int unsigned K_MAX          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] k_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       prod_start,
    input  logic       prod_done,
    output logic [1:0] acc_mode,
    output logic       acc_end_op_ntt,
    input  logic       acc_end_op,
    output logic       acc_load,
    output logic       acc_read,
    output logic       row_valid,
    input  logic       row_ack
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("acc_seq: TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    state_e           state_q, state_n;
    logic [IDX_W-1:0] row_q, row_n;
    logic [IDX_W-1:0] col_q, col_n;
    logic [K_W-1:0]   k_q, k_n;
    logic             err_q, err_n;
    ctl_t             ctl_q, ctl_n;
    logic [IDX_W-1:0] last_idx;
    logic             wdt_fire_c;

    assign last_idx = IDX_W'(k_q - K_W'(1));

`ifdef ACC_SEQ_TIMEOUT_EN
    logic in_wait;
    logic state_chg;

    assign in_wait   = (state_q == S_WAIT_PROD) || (state_q == S_WAIT_ACC);
    assign state_chg = (state_n != state_q);

    acc_seq_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .en     (in_wait),
        .clr    (state_chg),
        .fire_c (wdt_fire_c)
    );
`else
    assign wdt_fire_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_n;
            row_q   <= row_n;
            col_q   <= col_n;
            k_q     <= k_n;
            err_q   <= err_n;
            ctl_q   <= ctl_n;
        end
    end

    // Next state, indices and the registered control bundle decoded from the next state.
    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        col_n   = col_q;
        k_n     = k_q;
        err_n   = err_q;
        ctl_n   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rank_legal(k_in, K_MAX)) begin
                        k_n     = k_in;
                        row_n   = '0;
                        col_n   = '0;
                        err_n   = 1'b0;
                        state_n = S_PROD;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_PROD:      state_n = S_WAIT_PROD;
            S_WAIT_PROD: if (prod_done) state_n = S_ACC_GO;
            S_ACC_GO:    state_n = S_WAIT_ACC;
            S_WAIT_ACC:  if (acc_end_op) state_n = S_ACC_REL;
            S_ACC_REL: begin
                if (col_q == last_idx) begin
                    state_n = S_ROW_RDY;
                end else begin
                    col_n   = col_q + IDX_W'(1);
                    state_n = S_PROD;
                end
            end
            S_ROW_RDY: begin
                if (row_ack) begin
                    if (row_q == last_idx) begin
                        state_n = S_DONE;
                    end else begin
                        row_n   = row_q + IDX_W'(1);
                        col_n   = '0;
                        state_n = S_PROD;
                    end
                end
            end
            S_DONE:      state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase

        // A stalled responder aborts the schedule and releases the accumulator.
        if (wdt_fire_c) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
        end

        ctl_n.busy           = (state_n != S_IDLE);
        ctl_n.done           = (state_n == S_DONE);
        ctl_n.prod_start     = (state_n == S_PROD);
        ctl_n.acc_end_op_ntt = (state_n == S_ACC_GO);
        ctl_n.acc_load       = (state_n == S_ACC_REL) || wdt_fire_c;
        ctl_n.acc_read       = (state_n == S_ROW_RDY);
        ctl_n.row_valid      = (state_n == S_ROW_RDY);
        ctl_n.acc_mode       = mode_of(state_n, col_n);
    end

    assign busy           = ctl_q.busy;
    assign done           = ctl_q.done;
    assign err            = err_q;
    assign row            = row_q;
    assign col            = col_q;
    assign prod_start     = ctl_q.prod_start;
    assign acc_mode       = ctl_q.acc_mode;
    assign acc_end_op_ntt = ctl_q.acc_end_op_ntt;
    assign acc_load       = ctl_q.acc_load;
    assign acc_read       = ctl_q.acc_read;
    assign row_valid      = ctl_q.row_valid;

endmodule

// File: tb/tb_acc_seq.sv
// Self-checking bench for acc_seq: vector table, randomized schedules against a
// nested row/column reference, and hand-written reset/spurious/timeout sequences.
module tb_acc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] k_in = 3'd0;
    logic       busy, done, err;
    logic [1:0] row, col;
    logic       prod_start;
    logic       prod_done = 1'b0;
    logic [1:0] acc_mode;
    logic       acc_end_op_ntt;
    logic       acc_end_op = 1'b0;
    logic       acc_load, acc_read, row_valid;
    logic       row_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_prod = 0;
    int n_load = 0;
    int n_done = 0;

    acc_seq #(
        .K_MAX          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .k_in           (k_in),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .row            (row),
        .col            (col),
        .prod_start     (prod_start),
        .prod_done      (prod_done),
        .acc_mode       (acc_mode),
        .acc_end_op_ntt (acc_end_op_ntt),
        .acc_end_op     (acc_end_op),
        .acc_load       (acc_load),
        .acc_read       (acc_read),
        .row_valid      (row_valid),
        .row_ack        (row_ack)
    );

    always #5 clk = ~clk;

    // Pulse counters observed away from the active edge.
    always @(negedge clk) begin
        if (prod_start === 1'b1) n_prod++;
        if (acc_load === 1'b1)   n_load++;
        if (done === 1'b1)       n_done++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".err"}, 32'(err), 0);
        chk({tag, ".row"}, 32'(row), 0);
        chk({tag, ".col"}, 32'(col), 0);
        chk({tag, ".prod_start"}, 32'(prod_start), 0);
        chk({tag, ".acc_mode"}, 32'(acc_mode), 0);
        chk({tag, ".acc_end_op_ntt"}, 32'(acc_end_op_ntt), 0);
        chk({tag, ".acc_load"}, 32'(acc_load), 0);
        chk({tag, ".acc_read"}, 32'(acc_read), 0);
        chk({tag, ".row_valid"}, 32'(row_valid), 0);
    endtask

    // Reference schedule: for every row, every column gets one product and one
    // accumulate pass; mode is FIRST on column 0 and NORMAL otherwise.
    task automatic run_sched(input logic [2:0] k, input int dp, input int da, input int dr,
                             input bit spurious, input int exp_products);
        int kk;
        int p0, l0, d0;
        logic [1:0] exp_mode;
        kk = int'(k);
        p0 = n_prod; l0 = n_load; d0 = n_done;
        start = 1'b1; k_in = k;
        step();
        start = 1'b0;
        chk("err_cleared", 32'(err), 0);
        for (int r = 0; r < kk; r++) begin
            for (int c = 0; c < kk; c++) begin
                exp_mode = (c == 0) ? 2'b10 : 2'b11;
                chk("prod_start", 32'(prod_start), 1);
                chk("row", 32'(row), 32'(r));
                chk("col", 32'(col), 32'(c));
                chk("mode_prod", 32'(acc_mode), 32'(exp_mode));
                chk("busy", 32'(busy), 1);
                if (spurious) begin
                    prod_done = 1'b1; acc_end_op = 1'b1; row_ack = 1'b1;
                    start = 1'b1; k_in = 3'd4;
                end
                for (int i = 0; i < dp; i++) begin
                    step();
                    prod_done = 1'b0; acc_end_op = 1'b0; row_ack = 1'b0; start = 1'b0;
                    chk("wait_prod_quiet", 32'({prod_start, acc_end_op_ntt}), 0);
                end
                prod_done = 1'b1;
                step();
                prod_done = 1'b0;
                chk("acc_end_op_ntt", 32'(acc_end_op_ntt), 1);
                chk("mode_go", 32'(acc_mode), 32'(exp_mode));
                for (int i = 0; i < da; i++) begin
                    step();
                    chk("wait_acc_quiet", 32'({acc_end_op_ntt, acc_load}), 0);
                end
                acc_end_op = 1'b1;
                step();
                acc_end_op = 1'b0;
                chk("acc_load", 32'(acc_load), 1);
                chk("mode_rel", 32'(acc_mode), 32'(exp_mode));
                step();
            end
            chk("row_valid", 32'({row_valid, acc_read}), 32'h3);
            chk("row_rdy_row", 32'(row), 32'(r));
            for (int i = 0; i < dr; i++) begin
                step();
                chk("row_valid_hold", 32'(row_valid), 1);
            end
            row_ack = 1'b1;
            step();
            row_ack = 1'b0;
            chk("row_valid_drop", 32'(row_valid), 0);
        end
        chk("done", 32'(done), 1);
        chk("mode_done", 32'(acc_mode), 0);
        step();
        chk("done_pulse_end", 32'({done, busy}), 0);
        chk("n_products", 32'(n_prod - p0), 32'(exp_products));
        chk("n_loads", 32'(n_load - l0), 32'(exp_products));
        chk("n_done", 32'(n_done - d0), 1);
    endtask

    typedef struct {
        logic [2:0] k;
        int         dp;
        int         da;
        int         dr;
        logic       exp_err;
        int         exp_products;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'd2, 3, 3, 2, 1'b0, 4};
        vecs[1] = '{3'd4, 1, 1, 0, 1'b0, 16};
        vecs[2] = '{3'd5, 1, 1, 0, 1'b1, 0};
        vecs[3] = '{3'd3, 2, 1, 1, 1'b0, 9};
        vecs[4] = '{3'd0, 1, 1, 0, 1'b1, 0};
        vecs[5] = '{3'd1, 1, 1, 0, 1'b1, 0};
        vecs[6] = '{3'd7, 1, 1, 0, 1'b1, 0};
        vecs[7] = '{3'd2, 1, 2, 0, 1'b0, 4};

        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].exp_err) begin
                start = 1'b1; k_in = vecs[v].k;
                step();
                start = 1'b0;
                chk("illegal_err", 32'(err), 1);
                chk("illegal_busy", 32'({busy, prod_start}), 0);
                step();
                chk("illegal_err_sticky", 32'({err, busy}), 32'h2);
            end else begin
                run_sched(vecs[v].k, vecs[v].dp, vecs[v].da, vecs[v].dr, 1'b0,
                          vecs[v].exp_products);
            end
        end

        // Spurious prod_done/acc_end_op/row_ack and a mid-run start during PROD.
        run_sched(3'd2, 2, 1, 1, 1'b1, 4);

        // Reset while waiting on the accumulator; the coinciding acc_end_op is lost.
        start = 1'b1; k_in = 3'd3;
        step();
        start = 1'b0;
        chk("rst_seq_prod", 32'(prod_start), 1);
        step();
        prod_done = 1'b1;
        step();
        prod_done = 1'b0;
        chk("rst_seq_go", 32'(acc_end_op_ntt), 1);
        step();
        chk("rst_seq_wait", 32'(busy), 1);
        rst = 1'b1; acc_end_op = 1'b1;
        step();
        rst = 1'b0; acc_end_op = 1'b0;
        chk_all_zero("rst_mid");
        step();
        chk("rst_no_release", 32'({acc_load, busy}), 0);
        run_sched(3'd2, 1, 1, 0, 1'b0, 4);

        for (int n = 0; n < 20; n++) begin
            int kr;
            kr = int'($urandom_range(4, 2));
            run_sched(3'(kr), int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
                      int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), kr * kr);
        end

`ifdef ACC_SEQ_TIMEOUT_EN
        // acc_end_op never arrives: release and abort after 16 wait cycles.
        begin
            int d0;
            d0 = n_done;
            start = 1'b1; k_in = 3'd2;
            step();
            start = 1'b0;
            step();
            prod_done = 1'b1;
            step();
            prod_done = 1'b0;
            chk("to_go", 32'(acc_end_op_ntt), 1);
            for (int i = 0; i < 16; i++) begin
                step();
                chk("to_waiting", 32'({acc_load, err, busy}), 32'h1);
            end
            step();
            chk("to_fire", 32'({acc_load, err, busy}), 32'h6);
            step();
            chk("to_idle", 32'({acc_load, err, busy, done}), 32'h4);
            chk("to_no_done", 32'(n_done - d0), 0);
            run_sched(3'd3, 1, 1, 0, 1'b0, 9);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
